byte_lane_data_memory: RTL and testbench

Parametrised data memory for the pipelined MIPS datapath's MEM stage, replacing the fixed 64-word, word-only data memory. It adds byte and halfword stores through byte-lane enables, plus sign- or zero-extended sub-word loads. It detects misaligned accesses and uses a valid/ready request handshake with a configurable number of wait states, so slower memory timing can be modelled and the pipeline can be stalled.

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_lane_align.sv | 39 +++
 rtl/byte_lane_data_memory.sv | 117 +++++++++++
 tb/tb_byte_lane_data_memory.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: size encodings, FSM states and alignment check for the byte-lane data memory
package dmem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic {IDLE, WAIT} state_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return (size == SIZE_HALF && addr_lo[0]) || (size == SIZE_WORD && addr_lo != 2'b00) || size == 2'b11;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane steering for stores, right-justify and extension for loads
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]              size,
    input  logic [1:0]              addr_lo,
    input  logic                    zero_ext,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH-1:0]   word,
    output logic [DATA_WIDTH/8-1:0] lane_en,
    output logic [DATA_WIDTH-1:0]   wdata_rep,
    output logic [DATA_WIDTH-1:0]   rdata
);
    localparam int LANES = DATA_WIDTH / 8;

    logic [15:0] sub;
    logic        ext_b, ext_h;

    assign lane_en = size == SIZE_BYTE ? LANES'(1) << addr_lo
                   : size == SIZE_HALF ? LANES'(3) << {addr_lo[1], 1'b0}
                   : size == SIZE_WORD ? {LANES{1'b1}} : '0;

    // sub-word data is replicated across lanes so the enable mask alone selects the target
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign wdata_rep[8*i +: 8] = size == SIZE_BYTE ? wdata[7:0]
                                   : size == SIZE_HALF ? wdata[8*(i%2) +: 8]
                                   : wdata[8*i +: 8];
    end

    assign sub   = 16'(word >> {addr_lo, 3'b000});
    assign ext_b = !zero_ext && sub[7];
    assign ext_h = !zero_ext && sub[15];
    assign rdata = size == SIZE_BYTE ? {{(DATA_WIDTH-8){ext_b}}, sub[7:0]}
                 : size == SIZE_HALF ? {{(DATA_WIDTH-16){ext_h}}, sub[15:0]}
                 : word;

endmodule

// File: rtl/byte_lane_data_memory.sv
// byte_lane_data_memory: MEM-stage data memory with byte lanes, sub-word loads and wait states
module byte_lane_data_memory
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic                  MemoryRead,
    input  logic                  MemoryWrite,
    input  logic [1:0]            Size,
    input  logic                  Unsigned,
    input  logic [31:0]           Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic                  RespValid,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  Misaligned
);
    localparam int LANES = DATA_WIDTH / 8;
    localparam int AW    = $clog2(DEPTH_WORDS);

    state_t                state, state_next;
    logic [3:0]            count, count_next;
    logic                  accept, fire, mis, do_write, do_load;
    logic [AW+1:0]         req_addr, cur_addr;
    logic [DATA_WIDTH-1:0] req_wdata, cur_wdata;
    logic [1:0]            req_size, cur_size;
    logic                  req_unsigned, cur_unsigned, req_read, cur_read, req_write, cur_write;
    logic [AW-1:0]         idx;
    logic [LANES-1:0]      lane_en;
    logic [DATA_WIDTH-1:0] wdata_rep, rdata;
    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
    logic                  unused_addr_hi;

    assign unused_addr_hi = ^Address[31:AW+2];
    assign ReqReady       = state == IDLE;
    assign accept         = ReqValid && ReqReady;

    // zero-wait accesses act on the live inputs at the accept edge, others on the latched request
    always_comb begin
        cur_addr     = state == IDLE ? Address[AW+1:0] : req_addr;
        cur_wdata    = state == IDLE ? WriteData : req_wdata;
        cur_size     = state == IDLE ? Size : req_size;
        cur_unsigned = state == IDLE ? Unsigned : req_unsigned;
        cur_read     = state == IDLE ? MemoryRead : req_read;
        cur_write    = state == IDLE ? MemoryWrite : req_write;
    end

    assign idx      = cur_addr[AW+1:2];
    assign mis      = (cur_read || cur_write) && is_misaligned(cur_size, cur_addr[1:0]);
    assign do_write = fire && cur_write && !mis;
    assign do_load  = fire && cur_read && !cur_write && !mis;

    always_comb begin
        state_next = state;
        count_next = count;
        fire       = 1'b0;
        if (state == IDLE && accept) begin
            fire       = WAIT_STATES == 0;
            state_next = WAIT_STATES == 0 ? IDLE : WAIT;
            count_next = 4'(WAIT_STATES);
        end else if (state == WAIT) begin
            count_next = count - 4'd1;
            fire       = count == 4'd1;
            state_next = count == 4'd1 ? IDLE : WAIT;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            count      <= '0;
            RespValid  <= 1'b0;
            ReadData   <= '0;
            Misaligned <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            RespValid  <= fire;
            ReadData   <= do_load ? rdata : '0;
            Misaligned <= fire && mis;
        end
    end

    always_ff @(posedge Clock) begin
        if (accept) begin
            req_addr     <= Address[AW+1:0];
            req_wdata    <= WriteData;
            req_size     <= Size;
            req_unsigned <= Unsigned;
            req_read     <= MemoryRead;
            req_write    <= MemoryWrite;
        end
    end

    always_ff @(posedge Clock) begin
        if (do_write)
            for (int i = 0; i < LANES; i++)
                if (lane_en[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
    end

    dmem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .size      (cur_size),
        .addr_lo   (cur_addr[1:0]),
        .zero_ext  (cur_unsigned),
        .wdata     (cur_wdata),
        .word      (mem[idx]),
        .lane_en   (lane_en),
        .wdata_rep (wdata_rep),
        .rdata     (rdata)
    );

endmodule

// File: tb/tb_byte_lane_data_memory.sv
// tb_byte_lane_data_memory: vector table on a zero-wait instance plus handshake and reset sequences on a 3-wait instance
module tb_byte_lane_data_memory;

    localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;

    typedef struct {
        logic        rd, wr;
        logic [1:0]  sz;
        logic        un;
        logic [31:0] addr, wd, exp_data;
        logic        exp_mis;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        mis;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid [2], ready [2], mrd [2], mwr [2], uns [2], resp [2], mis [2];
    logic [1:0]  size [2];
    logic [31:0] addr [2], wdata [2], rdata [2];

    logic [31:0] exp_data [2];
    logic        exp_mis [2];
    bit          got [2];
    int          acc_cyc [2];
    exp_t        q0 [$], q3 [$];
    vec_t        tbl [$];
    int          checks = 0, errors = 0, cyc = 0, run0 = 0, max_run0 = 0, a1;

    always #5 clk = ~clk;

    byte_lane_data_memory #(.DATA_WIDTH(32), .DEPTH_WORDS(64), .WAIT_STATES(0)) dut0 (
        .Clock(clk), .Reset_n(rst_n), .ReqValid(valid[0]), .ReqReady(ready[0]),
        .MemoryRead(mrd[0]), .MemoryWrite(mwr[0]), .Size(size[0]), .Unsigned(uns[0]),
        .Address(addr[0]), .WriteData(wdata[0]), .RespValid(resp[0]), .ReadData(rdata[0]),
        .Misaligned(mis[0])
    );

    byte_lane_data_memory #(.DATA_WIDTH(32), .DEPTH_WORDS(64), .WAIT_STATES(3)) dut3 (
        .Clock(clk), .Reset_n(rst_n), .ReqValid(valid[1]), .ReqReady(ready[1]),
        .MemoryRead(mrd[1]), .MemoryWrite(mwr[1]), .Size(size[1]), .Unsigned(uns[1]),
        .Address(addr[1]), .WriteData(wdata[1]), .RespValid(resp[1]), .ReadData(rdata[1]),
        .Misaligned(mis[1])
    );

    function automatic vec_t mk(input int r, input int w, input logic [1:0] s, input int u,
                                input logic [31:0] a, input logic [31:0] d, input logic [31:0] e, input int m);
        vec_t v;
        v.rd = r != 0; v.wr = w != 0; v.sz = s; v.un = u != 0;
        v.addr = a; v.wd = d; v.exp_data = e; v.exp_mis = m != 0;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, exp);
        end
    endtask

    task automatic handle(input int d);
        exp_t e;
        int   n;
        n = d == 0 ? q0.size() : q3.size();
        if (resp[d] && n == 0) begin
            checks++;
            errors++;
            $display("FAIL resp%0d_unexpected at cycle %0d: got RespValid=1, required 0", d, cyc);
        end else if (resp[d]) begin
            if (d == 0) e = q0.pop_front(); else e = q3.pop_front();
            check($sformatf("rdata%0d", d), rdata[d], e.data);
            check($sformatf("misaligned%0d", d), 32'(mis[d]), 32'(e.mis));
            check($sformatf("resp_cycle%0d", d), cyc, e.due);
        end else if (n > 0) begin
            if (d == 0) e = q0[0]; else e = q3[0];
            if (e.due < cyc) begin
                checks++;
                errors++;
                $display("FAIL resp%0d_missing at cycle %0d: got no RespValid, required one at cycle %0d", d, cyc, e.due);
                if (d == 0) void'(q0.pop_front()); else void'(q3.pop_front());
            end
        end
    endtask

    task automatic step();
        logic a [2];
        exp_t e;
        for (int d = 0; d < 2; d++) a[d] = rst_n && valid[d] && ready[d];
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (a[d]) begin
                got[d] = 1'b1;
                acc_cyc[d] = cyc;
                e.data = exp_data[d];
                e.mis = exp_mis[d];
                e.due = cyc + (d == 0 ? 0 : 3);
                if (d == 0) q0.push_back(e); else q3.push_back(e);
            end
        end
        @(negedge clk);
        run0 = resp[0] ? run0 + 1 : 0;
        if (run0 > max_run0) max_run0 = run0;
        for (int d = 0; d < 2; d++) handle(d);
    endtask

    task automatic issue(input int d, input vec_t v);
        valid[d] = 1'b1; mrd[d] = v.rd; mwr[d] = v.wr; size[d] = v.sz; uns[d] = v.un;
        addr[d] = v.addr; wdata[d] = v.wd; exp_data[d] = v.exp_data; exp_mis[d] = v.exp_mis;
        got[d] = 1'b0;
        for (int i = 0; i < 20 && !got[d]; i++) step();
        if (!got[d]) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout%0d at cycle %0d: got no accept, required one within 20 cycles", d, cyc);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            valid[d] = 1'b0; mrd[d] = 1'b0; mwr[d] = 1'b0; size[d] = W; uns[d] = 1'b0;
            addr[d] = '0; wdata[d] = '0; exp_data[d] = '0; exp_mis[d] = 1'b0;
        end
        tbl.push_back(mk(0, 1, W, 0, 32'h10,   32'hDEADBEEF, 32'h0,        0));
        tbl.push_back(mk(1, 0, W, 0, 32'h10,   32'h0,        32'hDEADBEEF, 0));
        tbl.push_back(mk(1, 0, B, 0, 32'h13,   32'h0,        32'hFFFFFFDE, 0));
        tbl.push_back(mk(1, 0, H, 1, 32'h12,   32'h0,        32'h0000DEAD, 0));
        tbl.push_back(mk(0, 1, W, 0, 32'h20,   32'h0,        32'h0,        0));
        tbl.push_back(mk(0, 1, B, 0, 32'h21,   32'hAAAAAA81, 32'h0,        0));
        tbl.push_back(mk(0, 1, B, 0, 32'h23,   32'h5555557F, 32'h0,        0));
        tbl.push_back(mk(1, 0, W, 0, 32'h20,   32'h0,        32'h7F008100, 0));
        tbl.push_back(mk(1, 0, B, 0, 32'h21,   32'h0,        32'hFFFFFF81, 0));
        tbl.push_back(mk(1, 0, B, 1, 32'h21,   32'h0,        32'h00000081, 0));
        tbl.push_back(mk(1, 0, B, 0, 32'h23,   32'h0,        32'h0000007F, 0));
        tbl.push_back(mk(0, 1, W, 0, 32'h30,   32'h11223344, 32'h0,        0));
        tbl.push_back(mk(0, 1, H, 0, 32'h32,   32'hCCCC8001, 32'h0,        0));
        tbl.push_back(mk(1, 0, H, 0, 32'h32,   32'h0,        32'hFFFF8001, 0));
        tbl.push_back(mk(1, 0, H, 1, 32'h32,   32'h0,        32'h00008001, 0));
        tbl.push_back(mk(1, 0, W, 1, 32'h30,   32'h0,        32'h80013344, 0));
        tbl.push_back(mk(1, 0, H, 0, 32'h30,   32'h0,        32'h00003344, 0));
        tbl.push_back(mk(0, 1, W, 0, 32'h40,   32'hCAFEF00D, 32'h0,        0));
        tbl.push_back(mk(0, 1, H, 0, 32'h41,   32'h00001234, 32'h0,        1));
        tbl.push_back(mk(1, 0, W, 0, 32'h42,   32'h0,        32'h0,        1));
        tbl.push_back(mk(1, 0, X, 0, 32'h40,   32'h0,        32'h0,        1));
        tbl.push_back(mk(1, 0, W, 0, 32'h40,   32'h0,        32'hCAFEF00D, 0));
        tbl.push_back(mk(1, 1, W, 0, 32'h44,   32'hA5A5A5A5, 32'h0,        0));
        tbl.push_back(mk(1, 0, W, 0, 32'h44,   32'h0,        32'hA5A5A5A5, 0));
        tbl.push_back(mk(0, 0, W, 0, 32'h41,   32'hFFFFFFFF, 32'h0,        0));
        tbl.push_back(mk(0, 1, W, 0, 32'h150,  32'h0BADF00D, 32'h0,        0));
        tbl.push_back(mk(1, 0, W, 0, 32'h50,   32'h0,        32'h0BADF00D, 0));
        tbl.push_back(mk(1, 0, B, 0, 32'h1040, 32'h0,        32'h0000000D, 0));

        repeat (2) step();
        rst_n = 1'b1;
        step();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("ready%0d_reset", d), 32'(ready[d]), 32'd1);
            check($sformatf("resp%0d_reset", d), 32'(resp[d]), 32'd0);
            check($sformatf("rdata%0d_reset", d), rdata[d], 32'd0);
            check($sformatf("mis%0d_reset", d), 32'(mis[d]), 32'd0);
        end

        foreach (tbl[i]) issue(0, tbl[i]);
        valid[0] = 1'b0;
        repeat (3) step();
        check("back_to_back_run0", max_run0, tbl.size());

        issue(1, mk(0, 1, W, 0, 32'h60, 32'h01020304, 32'h0, 0));
        valid[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("ready3_low_%0d", i), 32'(ready[1]), 32'd0);
            step();
        end
        check("ready3_in_resp_cycle", 32'(ready[1]), 32'd1);
        check("resp3_after_wait", 32'(resp[1]), 32'd1);

        issue(1, mk(1, 0, W, 0, 32'h60, 32'h0, 32'h01020304, 0));
        a1 = acc_cyc[1];
        issue(1, mk(1, 0, B, 1, 32'h61, 32'h0, 32'h00000003, 0));
        check("held_accept_gap", acc_cyc[1] - a1, 32'd4);
        valid[1] = 1'b0;
        repeat (5) step();

        issue(1, mk(0, 1, W, 0, 32'h150, 32'hAABBCCDD, 32'h0, 0));
        valid[1] = 1'b0;
        repeat (4) step();
        issue(1, mk(0, 1, W, 0, 32'h50, 32'h12345678, 32'h0, 0));
        valid[1] = 1'b0;
        step();
        rst_n = 1'b0;
        q3.delete();
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("resp3_in_reset_%0d", i), 32'(resp[1]), 32'd0);
        end
        rst_n = 1'b1;
        step();
        check("ready3_after_reset", 32'(ready[1]), 32'd1);
        check("resp3_after_reset", 32'(resp[1]), 32'd0);
        check("rdata3_after_reset", rdata[1], 32'd0);
        repeat (4) step();
        issue(1, mk(1, 0, W, 0, 32'h50, 32'h0, 32'hAABBCCDD, 0));
        issue(1, mk(1, 0, W, 0, 32'h150, 32'h0, 32'hAABBCCDD, 0));
        valid[1] = 1'b0;
        repeat (6) step();

        check("q0_drained", q0.size(), 32'd0);
        check("q3_drained", q3.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
